// File: rtl/seg_spinner_pkg.sv
// rtl/seg_spinner_pkg.sv - segment indices, seg_t and perimeter position to {digit, segment} mapping
package seg_spinner_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam int POS_W_MAX = 5;

    typedef logic [6:0] seg_t;

    typedef struct packed {
        logic [2:0] digit;
        logic [2:0] seg;
    } digit_seg_t;

    // Top edge runs left to right, down the right side, bottom right to left, up the left side
    function automatic digit_seg_t pos_to_digit_seg(input logic [POS_W_MAX-1:0] p, input int n);
        digit_seg_t r;
        int         pi;
        pi = int'(p);
        if (pi < n) begin
            r.digit = 3'(n - 1 - pi);
            r.seg   = 3'(SEG_A);
        end else if (pi == n) begin
            r.digit = 3'd0;
            r.seg   = 3'(SEG_B);
        end else if (pi == n + 1) begin
            r.digit = 3'd0;
            r.seg   = 3'(SEG_C);
        end else if (pi < 2 * n + 2) begin
            r.digit = 3'(pi - n - 2);
            r.seg   = 3'(SEG_D);
        end else if (pi == 2 * n + 2) begin
            r.digit = 3'(n - 1);
            r.seg   = 3'(SEG_E);
        end else begin
            r.digit = 3'(n - 1);
            r.seg   = 3'(SEG_F);
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_spinner_tick_gen.sv
// rtl/seg_spinner_tick_gen.sv - tick_gen: speed-selectable prescaler producing the animation step
module tick_gen #(
    parameter int DIV_BASE = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_speed,
    output logic       o_step
);

    // Wide enough for the slowest setting, DIV_BASE << 3
    localparam int CNT_W = $clog2(DIV_BASE * 8);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_limit;

    assign w_limit = CNT_W'((DIV_BASE << i_speed) - 1);
    assign o_step  = i_en && (r_cnt == w_limit);

    // Overshoot after a speed decrease clears silently; only an exact match steps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (r_cnt >= w_limit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_spinner.sv
// rtl/seg_spinner.sv - seven-segment perimeter spinner with multiplexed scan
// Optional two-segment trail: define SEG_SPINNER_TRAIL_EN.
module seg_spinner
    import seg_spinner_pkg::*;
#(
    parameter int N_DIGITS  = 8,
    parameter int DIV_BASE  = 12_500_000,
    parameter int SCAN_BITS = 17
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en,
    input  logic                                cw,
    input  logic [1:0]                          speed,
    output logic [N_DIGITS-1:0]                 an,
    output logic [6:0]                          seg,
    output logic [$clog2(2*N_DIGITS+4)-1:0]     pos,
    output logic                                lap
);

    localparam int P     = 2 * N_DIGITS + 4;
    localparam int POS_W = $clog2(P);

    logic [POS_W-1:0]     r_pos;
    logic                 r_lap;
    logic [SCAN_BITS-1:0] r_scan_div;
    logic [2:0]           r_digit;
    logic [N_DIGITS-1:0]  r_an;
    seg_t                 r_seg;

    logic                 w_step;
    logic                 w_pos_last;
    logic                 w_pos_first;
    digit_seg_t           w_head;
    seg_t                 w_lit;
    logic [N_DIGITS-1:0]  w_an;

    tick_gen #(
        .DIV_BASE (DIV_BASE)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (en),
        .i_speed (speed),
        .o_step  (w_step)
    );

    assign w_pos_last  = (r_pos == POS_W'(P - 1));
    assign w_pos_first = (r_pos == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= '0;
            r_lap <= 1'b0;
        end else begin
            r_lap <= w_step && (cw ? w_pos_last : w_pos_first);
            if (w_step) begin
                if (cw) begin
                    r_pos <= w_pos_last ? '0 : r_pos + 1'b1;
                end else begin
                    r_pos <= w_pos_first ? POS_W'(P - 1) : r_pos - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_div <= '0;
            r_digit    <= '0;
        end else begin
            r_scan_div <= r_scan_div + 1'b1;
            if (&r_scan_div) begin
                r_digit <= (r_digit == 3'(N_DIGITS - 1)) ? 3'd0 : r_digit + 3'd1;
            end
        end
    end

    assign w_head = pos_to_digit_seg(POS_W_MAX'(r_pos), N_DIGITS);

`ifdef SEG_SPINNER_TRAIL_EN
    logic [POS_W-1:0] w_prev;
    digit_seg_t       w_tail;

    assign w_prev = cw ? (w_pos_first ? POS_W'(P - 1) : r_pos - 1'b1)
                       : (w_pos_last  ? '0            : r_pos + 1'b1);
    assign w_tail = pos_to_digit_seg(POS_W_MAX'(w_prev), N_DIGITS);
`endif

    always_comb begin
        w_lit = '0;
        if (w_head.digit == r_digit) begin
            w_lit[w_head.seg] = 1'b1;
        end
`ifdef SEG_SPINNER_TRAIL_EN
        if (w_tail.digit == r_digit) begin
            w_lit[w_tail.seg] = 1'b1;
        end
`endif
    end

    always_comb begin
        w_an = '1;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (r_digit == 3'(d) && |w_lit) begin
                w_an[d] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= '1;
            r_seg <= 7'h7F;
        end else begin
            r_an  <= w_an;
            r_seg <= ~w_lit;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign pos = r_pos;
    assign lap = r_lap;

endmodule

// File: tb/tb_seg_spinner.sv
// tb/tb_seg_spinner.sv - directed self-checking bench for seg_spinner (N_DIGITS=4, DIV_BASE=4, SCAN_BITS=1)
module tb_seg_spinner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       cw;
    logic [1:0] speed;
    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] pos;
    logic       lap;

    int checks = 0;
    int errors = 0;
    int hits;
    logic ok;

`ifdef SEG_SPINNER_TRAIL_EN
    localparam logic [6:0] EXP_D0_POS4 = 7'b1111100;
`else
    localparam logic [6:0] EXP_D0_POS4 = 7'b1111101;
`endif

    seg_spinner #(
        .N_DIGITS  (4),
        .DIV_BASE  (4),
        .SCAN_BITS (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .cw    (cw),
        .speed (speed),
        .an    (an),
        .seg   (seg),
        .pos   (pos),
        .lap   (lap)
    );

    always #5 clk = ~clk;

    task automatic step_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        cw    = 1'b1;
        speed = 2'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pos", pos, 0);
        chk("rst_an",  an,  4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_lap", lap, 0);

        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step_clk(3);
            chk("cw_hold", pos, k);
            chk("cw_hold_lap", lap, 0);
            step_clk(1);
            chk("cw_step", pos, (k + 1) % 12);
            chk("cw_lap", lap, (k == 11) ? 1 : 0);
        end
        step_clk(1);
        chk("lap_one_cycle", lap, 0);
        chk("wrap_pos", pos, 0);

        cw = 1'b0;
        step_clk(3);
        chk("ccw_wrap_pos", pos, 11);
        chk("ccw_wrap_lap", lap, 1);
        step_clk(4);
        chk("ccw_pos10", pos, 10);
        chk("ccw_lap_clr", lap, 0);

        cw = 1'b1;
        step_clk(28);
        chk("reach_pos5", pos, 5);
        en = 1'b0;
        step_clk(2);
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            step_clk(1);
            ok = (an == 4'b1110 && seg == 7'b1111011) || (an == 4'b1111 && seg == 7'h7F);
            chk("scan_pos5", ok, 1);
            if (an == 4'b1110) hits++;
        end
        chk("scan_pos5_d0_slots", hits, 4);
        chk("scan_pos5_hold", pos, 5);

        en = 1'b1;
        step_clk(8);
        chk("reach_pos7", pos, 7);
        en = 1'b0;
        hits = 0;
        for (int i = 0; i < 50; i++) begin
            step_clk(1);
            chk("frz_pos", pos, 7);
            chk("frz_lap", lap, 0);
            ok = (an == 4'b1101 && seg == 7'b1110111) || (an == 4'b1111 && seg == 7'h7F);
            chk("frz_scan", ok, 1);
            if (an == 4'b1101) hits++;
        end
        chk("frz_scan_active", (hits >= 12 && hits <= 14) ? 1 : 0, 1);

        speed = 2'd3;
        en    = 1'b1;
        step_clk(31);
        chk("spd3_hold", pos, 7);
        step_clk(1);
        chk("spd3_step", pos, 8);
        step_clk(20);
        speed = 2'd0;
        step_clk(1);
        chk("spd_clear_nostep", pos, 8);
        step_clk(3);
        chk("spd0_hold", pos, 8);
        step_clk(1);
        chk("spd0_step", pos, 9);
        step_clk(4);
        chk("spd0_step2", pos, 10);

        step_clk(24);
        chk("reach_pos4", pos, 4);
        en = 1'b0;
        step_clk(2);
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            step_clk(1);
            ok = (an == 4'b1110 && seg == EXP_D0_POS4) || (an == 4'b1111 && seg == 7'h7F);
            chk("scan_pos4", ok, 1);
            if (an == 4'b1110) hits++;
        end
        chk("scan_pos4_d0_slots", hits, 4);

        en = 1'b1;
        step_clk(3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pos", pos, 0);
        chk("mid_rst_an",  an,  4'hF);
        chk("mid_rst_seg", seg, 7'h7F);
        chk("mid_rst_lap", lap, 0);
        step_clk(1);
        chk("mid_rst_hold", pos, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step_clk(3);
        chk("post_rst_hold", pos, 0);
        step_clk(1);
        chk("post_rst_step", pos, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_spinner.md
SEG_SPINNER -- requirements
Module: seg_spinner

Interface
REQ-001 Parameter N_DIGITS, default 8: number of seven-segment digits driven; legal 2..8.
REQ-002 Parameter DIV_BASE, default 12_500_000: clock cycles per step at speed 0; legal >= 2.
REQ-003 Parameter SCAN_BITS, default 17: each digit is strobed for 2^SCAN_BITS cycles.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  1 = animation runs, 0 = animation frozen.
REQ-007 cw  in  1  1 = clockwise travel, 0 = counter-clockwise.
REQ-008 speed  in  2  step-period select.
REQ-009 an  out  N_DIGITS  digit enables, active-low; an[0] is the rightmost digit.
REQ-010 seg  out  7  segment drives {G,F,E,D,C,B,A}, active-low.
REQ-011 pos  out  $clog2(2*N_DIGITS+4)  current head position.
REQ-012 lap  out  1  one-cycle pulse on each perimeter wrap.

Function
REQ-013 The perimeter SHALL have P = 2*N_DIGITS+4 positions, mapped as follows:
  - p in 0..N-1: digit N-1-p, segment A;
  - p = N: digit 0, segment B;
  - p = N+1: digit 0, segment C;
  - p = N+2+k, k in 0..N-1: digit k, segment D;
  - p = 2N+2: digit N-1, segment E;
  - p = 2N+3: digit N-1, segment F.
REQ-014 The prescaler SHALL count to L = (DIV_BASE << speed) - 1; it SHALL be sized for speed = 3 with no overflow.
REQ-015 While en = 1, on the cycle the prescaler equals L it SHALL clear to 0 and assert an internal step; otherwise it increments.
REQ-016 On step, pos SHALL advance +1 (cw = 1) or -1 (cw = 0) modulo P.
REQ-017 lap SHALL pulse for one cycle on the cycle after a step that takes pos P-1 -> 0 (cw) or 0 -> P-1 (ccw).
REQ-018 While en = 0:
  - prescaler and pos SHALL hold;
  - no step or lap SHALL occur;
  - the display SHALL keep scanning.
REQ-019 cw and speed SHALL be sampled every cycle; a change SHALL take effect from the next prescaler comparison.
REQ-020 If speed changes such that the prescaler already exceeds the new L, the prescaler SHALL clear to 0 without a step.
REQ-021 A scan counter SHALL select digit d = cycle index modulo N_DIGITS, advancing every 2^SCAN_BITS cycles regardless of en.
REQ-022 an[d] SHALL be 0 only if digit d holds a lit segment; all other an bits SHALL be 1.
REQ-023 seg SHALL be the active-low OR of the lit segments in digit d.
REQ-024 an and seg SHALL be registered, one cycle behind the scan counter and pos.

Reset
REQ-025 While rst_n = 0, independent of clk:
  - pos = 0, prescaler = 0, scan = 0;
  - an = all ones, seg = 7'h7F, lap = 0.
REQ-026 After rst_n deasserts, the first step SHALL occur L+1 enabled cycles later.
REQ-027 Reset asserted mid-step SHALL discard the pending step and lap.

Configuration
REQ-028 With SEG_SPINNER_TRAIL_EN defined, the segment at the previous position (pos-1 if cw = 1, pos+1 if cw = 0, modulo P) SHALL also be lit, giving two lit segments.
REQ-029 Without SEG_SPINNER_TRAIL_EN, exactly one segment SHALL be lit and the trail logic SHALL be absent.

Structure
REQ-030 Package seg_spinner_pkg SHALL hold:
  - segment index constants SEG_A..SEG_G;
  - typedef seg_t (7-bit);
  - function pos_to_digit_seg mapping a position to {digit, segment}.
REQ-031 Sub-module tick_gen SHALL contain the prescaler (en, speed, step); everything else stays in seg_spinner.

Verification (N_DIGITS=4, DIV_BASE=4, SCAN_BITS=1, P=12)
REQ-032 Reset, en=1, cw=1, speed=0: pos steps every 4 cycles 0,1,...,11,0; lap is high exactly one cycle after 11->0.
REQ-033 cw=0 from pos=0: next pos is 11 with a lap pulse, then 10.
REQ-034 pos=5 (digit 0, seg C), all digits scanned: an=4'b1110 only in digit-0 slots with seg=7'b1111011; an=4'b1111 in all other slots.
REQ-035 speed=3: step period is 32 cycles; switching to speed=0 with prescaler at 20 clears the prescaler, then steps every 4 cycles.
REQ-036 en=0 for 50 cycles at pos=7: pos stays 7, no lap; scanning continues.
REQ-037 With SEG_SPINNER_TRAIL_EN, cw=1, pos=4: digit 0 slot shows seg=7'b1111100 (A and B lit); rst_n pulsed low mid-run: outputs return to reset values immediately.
